// File: rtl/atahost_pio_engine.sv
// Purpose: executes one ATA PIO register/data cycle per request, with per-transfer timing-set select and IORDY stretch.
// Latency: ack_o in the last RECOV cycle, (T1+1)+(T2+1+stretch)+(T4+1)+(Teoc+1) cycles after the req sample edge.
// Backpressure: req_i is sampled only while idle; busy_o is high for the whole transfer and at least one idle cycle follows each ack.
module atahost_pio_engine #(
    parameter int TWIDTH   = 8,
    parameter int SW       = 1,
    parameter int T1_RST   = 6,
    parameter int T2_RST   = 28,
    parameter int T4_RST   = 2,
    parameter int TEOC_RST = 23,
    parameter int TOW      = 8,
    parameter int TOUT     = 125
) (
    input  logic                  wb_clk_i,
    input  logic                  arst_i,
    input  logic                  wb_rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [3:0]            a_i,
    input  logic [15:0]           d_i,
    input  logic [SW-1:0]         tsel_i,
    input  logic                  iordy_en_i,
    input  logic                  tload_i,
    input  logic [SW-1:0]         tload_sel_i,
    input  logic [4*TWIDTH-1:0]   tload_d_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [15:0]           q_o,
    input  logic [15:0]           dd_pad_i,
    output logic [15:0]           dd_pad_o,
    output logic                  dd_padoe_o,
    output logic [2:0]            da_pad_o,
    output logic                  cs0n_pad_o,
    output logic                  cs1n_pad_o,
    output logic                  diorn_pad_o,
    output logic                  diown_pad_o,
    input  logic                  iordy_pad_i
);

    localparam int NSETS = 2 ** SW;

    // Packed reset word in the same {Teoc, T4, T2, T1} layout as tload_d_i.
    localparam logic [4*TWIDTH-1:0] TSET_RST = {TWIDTH'(TEOC_RST), TWIDTH'(T4_RST),
                                                TWIDTH'(T2_RST),   TWIDTH'(T1_RST)};
    localparam logic [TOW-1:0]      TOUT_V   = TOW'(TOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RECOV  = 3'd4
    } state_t;

    state_t                          state;
    logic [NSETS-1:0][4*TWIDTH-1:0]  tset;
    logic [4*TWIDTH-1:0]             sel_set;
    logic [TWIDTH-1:0]               sel_t1;
    logic [TWIDTH-1:0]               sel_t2;
    logic [TWIDTH-1:0]               sel_t4;
    logic [TWIDTH-1:0]               sel_teoc;

    // Working copies taken at request time so later loads cannot disturb a running transfer.
    logic [TWIDTH-1:0]               w_t2;
    logic [TWIDTH-1:0]               w_t4;
    logic [TWIDTH-1:0]               w_teoc;
    logic [TWIDTH-1:0]               cnt;
    logic [TOW-1:0]                  tout_cnt;
    logic                            we_r;
    logic                            iordy_en_r;
    logic                            err_flag;
    logic                            iordy_s1;
    logic                            iordy_s2;
    logic                            iordy_wait;

    // Read port of the timing-set bank; a same-cycle load is not visible here yet.
    assign sel_set  = tset[tsel_i];
    assign sel_t1   = sel_set[TWIDTH-1:0];
    assign sel_t2   = sel_set[2*TWIDTH-1:TWIDTH];
    assign sel_t4   = sel_set[3*TWIDTH-1:2*TWIDTH];
    assign sel_teoc = sel_set[4*TWIDTH-1:3*TWIDTH];

    // Device asks for more time only when stretching is enabled for this transfer.
    assign iordy_wait = iordy_en_r & ~iordy_s2;

    // Timing-set bank: one set written per cycle, restored by either reset.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            tset <= {NSETS{TSET_RST}};
        end else if (wb_rst_i) begin
            tset <= {NSETS{TSET_RST}};
        end else if (tload_i) begin
            tset[tload_sel_i] <= tload_d_i;
        end
    end

    // Two-flop synchroniser for the asynchronous IORDY pad.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            iordy_s1 <= 1'b0;
            iordy_s2 <= 1'b0;
        end else begin
            iordy_s1 <= iordy_pad_i;
            iordy_s2 <= iordy_s1;
        end
    end

    // Transfer sequencer; every pad and handshake output is registered on the transition into its phase.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            tout_cnt    <= '0;
            w_t2        <= '0;
            w_t4        <= '0;
            w_teoc      <= '0;
            we_r        <= 1'b0;
            iordy_en_r  <= 1'b0;
            err_flag    <= 1'b0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            q_o         <= '0;
            dd_pad_o    <= '0;
            dd_padoe_o  <= 1'b0;
            da_pad_o    <= '0;
            cs0n_pad_o  <= 1'b1;
            cs1n_pad_o  <= 1'b1;
            diorn_pad_o <= 1'b1;
            diown_pad_o <= 1'b1;
        end else if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            tout_cnt    <= '0;
            w_t2        <= '0;
            w_t4        <= '0;
            w_teoc      <= '0;
            we_r        <= 1'b0;
            iordy_en_r  <= 1'b0;
            err_flag    <= 1'b0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            q_o         <= '0;
            dd_pad_o    <= '0;
            dd_padoe_o  <= 1'b0;
            da_pad_o    <= '0;
            cs0n_pad_o  <= 1'b1;
            cs1n_pad_o  <= 1'b1;
            diorn_pad_o <= 1'b1;
            diown_pad_o <= 1'b1;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        state      <= SETUP;
                        busy_o     <= 1'b1;
                        we_r       <= we_i;
                        iordy_en_r <= iordy_en_i;
                        err_flag   <= 1'b0;
                        cnt        <= sel_t1;
                        w_t2       <= sel_t2;
                        w_t4       <= sel_t4;
                        w_teoc     <= sel_teoc;
                        da_pad_o   <= a_i[2:0];
                        cs0n_pad_o <= a_i[3];
                        cs1n_pad_o <= ~a_i[3];
                        if (we_i) begin
                            dd_pad_o   <= d_i;
                            dd_padoe_o <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state       <= STROBE;
                        cnt         <= w_t2;
                        tout_cnt    <= '0;
                        diorn_pad_o <= we_r;
                        diown_pad_o <= ~we_r;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (iordy_wait && (tout_cnt != TOUT_V)) begin
                        // Stretch one more cycle; the bound keeps a dead device from hanging the bus.
                        tout_cnt <= tout_cnt + 1'b1;
                    end else begin
                        state       <= HOLD;
                        cnt         <= w_t4;
                        diorn_pad_o <= 1'b1;
                        diown_pad_o <= 1'b1;
                        // Still waiting here means the stretch budget ran out.
                        if (iordy_wait) begin
                            err_flag <= 1'b1;
                        end
                        if (!we_r) begin
                            q_o <= dd_pad_i;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state      <= RECOV;
                        cnt        <= w_teoc;
                        cs0n_pad_o <= 1'b1;
                        cs1n_pad_o <= 1'b1;
                        dd_padoe_o <= 1'b0;
                        dd_pad_o   <= '0;
                        // A one-cycle recovery is itself the last RECOV cycle.
                        if (w_teoc == '0) begin
                            ack_o <= 1'b1;
                            err_o <= err_flag;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOV: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        da_pad_o <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Next cycle is the last one of recovery: flag completion there.
                        if (cnt == TWIDTH'(1)) begin
                            ack_o <= 1'b1;
                            err_o <= err_flag;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atahost_pio_engine.sv
// Purpose: exercises PIO reads/writes, timing-set loads, IORDY stretch/timeout and resets against a scoreboard.
// Latency: expectations are pushed at request time and popped when ack_o is seen.
// Backpressure: each transfer waits for busy_o to drop, bounded by a cycle budget.
module tb_atahost_pio_engine;

    localparam int TW   = 8;
    localparam int SW   = 1;
    localparam int TOUT = 125;

    logic              wb_clk_i = 1'b0;
    logic              arst_i;
    logic              wb_rst_i;
    logic              req_i;
    logic              we_i;
    logic [3:0]        a_i;
    logic [15:0]       d_i;
    logic [SW-1:0]     tsel_i;
    logic              iordy_en_i;
    logic              tload_i;
    logic [SW-1:0]     tload_sel_i;
    logic [4*TW-1:0]   tload_d_i;
    logic              ack_o;
    logic              err_o;
    logic              busy_o;
    logic [15:0]       q_o;
    logic [15:0]       dd_pad_i;
    logic [15:0]       dd_pad_o;
    logic              dd_padoe_o;
    logic [2:0]        da_pad_o;
    logic              cs0n_pad_o;
    logic              cs1n_pad_o;
    logic              diorn_pad_o;
    logic              diown_pad_o;
    logic              iordy_pad_i;

    atahost_pio_engine #(
        .TWIDTH(TW), .SW(SW), .T1_RST(6), .T2_RST(28), .T4_RST(2), .TEOC_RST(23),
        .TOW(8), .TOUT(TOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .arst_i(arst_i), .wb_rst_i(wb_rst_i),
        .req_i(req_i), .we_i(we_i), .a_i(a_i), .d_i(d_i), .tsel_i(tsel_i),
        .iordy_en_i(iordy_en_i), .tload_i(tload_i), .tload_sel_i(tload_sel_i),
        .tload_d_i(tload_d_i), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
        .q_o(q_o), .dd_pad_i(dd_pad_i), .dd_pad_o(dd_pad_o), .dd_padoe_o(dd_padoe_o),
        .da_pad_o(da_pad_o), .cs0n_pad_o(cs0n_pad_o), .cs1n_pad_o(cs1n_pad_o),
        .diorn_pad_o(diorn_pad_o), .diown_pad_o(diown_pad_o), .iordy_pad_i(iordy_pad_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [15:0] q;
        logic        err;
        int          lat;
        int          strb;
        int          oe;
        int          csl;
        logic [2:0]  da;
        logic [1:0]  cs;
        logic [15:0] dd;
    } exp_t;

    exp_t        sb[$];
    int          tm[2][4];          // model timing sets: t1, t2, t4, teoc
    logic [15:0] last_q;
    int          checks   = 0;
    int          failures = 0;

    // Pending same-cycle timing load applied together with the next request.
    logic        sim_ld   = 1'b0;
    int          sim_vals[4];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            tm[s][0] = 6; tm[s][1] = 28; tm[s][2] = 2; tm[s][3] = 23;
        end
        last_q = 16'h0000;
    endtask

    task automatic load_set(input int s, input int t1, input int t2, input int t4, input int teoc);
        @(negedge wb_clk_i);
        tload_i     = 1'b1;
        tload_sel_i = SW'(s);
        tload_d_i   = {8'(teoc), 8'(t4), 8'(t2), 8'(t1)};
        @(posedge wb_clk_i);
        #1 tload_i = 1'b0;
        tm[s][0] = t1; tm[s][1] = t2; tm[s][2] = t4; tm[s][3] = teoc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (busy_o && n < 3000);
        check({tag, "_done"}, 32'(n < 3000), 32'd1);
        check({tag, "_acked"}, 32'(sb.size()), 32'd0);
    endtask

    // Pushes the expected outcome, issues one request, then waits for completion.
    task automatic xfer(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d,
                        input int s, input logic ien, input int stretch, input logic err,
                        input logic [15:0] rdata);
        exp_t e;
        int   body;
        body   = tm[s][0] + tm[s][1] + tm[s][2] + 3 + stretch;
        e.lat  = body + tm[s][3] + 1;
        e.strb = tm[s][1] + 1 + stretch;
        e.oe   = we ? body : 0;
        e.csl  = body;
        e.da   = a[2:0];
        e.cs   = a[3] ? 2'b01 : 2'b10;
        e.dd   = we ? d : 16'h0000;
        e.err  = err;
        if (!we) last_q = rdata;
        e.q    = last_q;
        sb.push_back(e);
        @(negedge wb_clk_i);
        dd_pad_i   = rdata;
        req_i      = 1'b1;
        we_i       = we;
        a_i        = a;
        d_i        = d;
        tsel_i     = SW'(s);
        iordy_en_i = ien;
        if (sim_ld) begin
            tload_i     = 1'b1;
            tload_sel_i = SW'(s);
            tload_d_i   = {8'(sim_vals[3]), 8'(sim_vals[2]), 8'(sim_vals[1]), 8'(sim_vals[0])};
        end
        @(posedge wb_clk_i);
        #1;
        req_i   = 1'b0;
        tload_i = 1'b0;
        if (sim_ld) begin
            for (int k = 0; k < 4; k++) tm[s][k] = sim_vals[k];
            sim_ld = 1'b0;
        end
        wait_idle(tag);
    endtask

    task automatic wait_strobe(output bit ok);
        int n;
        n = 0;
        while (diorn_pad_o && diown_pad_o && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        ok = (n < 300);
    endtask

    // Transfer monitor: measures phase lengths while busy and retires expectations on ack.
    int          m_lat, m_strb, m_oe, m_csl;
    logic [2:0]  m_da;
    logic [1:0]  m_cs;
    logic [15:0] m_dd;
    exp_t        m_e;

    always @(negedge wb_clk_i) begin
        if (!busy_o) begin
            m_lat = 0; m_strb = 0; m_oe = 0; m_csl = 0;
        end else begin
            if (m_lat == 0) begin
                m_da = da_pad_o;
                m_cs = {cs1n_pad_o, cs0n_pad_o};
                m_dd = dd_pad_o;
            end
            m_lat++;
            if (!diorn_pad_o || !diown_pad_o) m_strb++;
            if (dd_padoe_o) m_oe++;
            if (!cs0n_pad_o || !cs1n_pad_o) m_csl++;
        end
        if (ack_o) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("latency", 32'(m_lat), 32'(m_e.lat));
                check("strobe_len", 32'(m_strb), 32'(m_e.strb));
                check("oe_len", 32'(m_oe), 32'(m_e.oe));
                check("cs_len", 32'(m_csl), 32'(m_e.csl));
                check("da", 32'(m_da), 32'(m_e.da));
                check("cs_sel", 32'(m_cs), 32'(m_e.cs));
                check("dd_out", 32'(m_dd), 32'(m_e.dd));
                check("q", 32'(q_o), 32'(m_e.q));
                check("err", 32'(err_o), 32'(m_e.err));
            end
        end else if (err_o) begin
            check("err_without_ack", 32'd1, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        arst_i = 1'b1; wb_rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; a_i = '0; d_i = '0;
        tsel_i = '0; iordy_en_i = 1'b0; tload_i = 1'b0; tload_sel_i = '0; tload_d_i = '0;
        dd_pad_i = '0; iordy_pad_i = 1'b1;
        model_reset();
        #12;
        check("rst_diorn", 32'(diorn_pad_o), 32'd1);
        check("rst_diown", 32'(diown_pad_o), 32'd1);
        check("rst_cs", 32'({cs1n_pad_o, cs0n_pad_o}), 32'd3);
        check("rst_da_dd", 32'({da_pad_o, dd_pad_o, dd_padoe_o}), 32'd0);
        check("rst_ack_err_busy", 32'({ack_o, err_o, busy_o}), 32'd0);
        check("rst_q", 32'(q_o), 32'd0);
        @(negedge wb_clk_i);
        arst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        // Default read from CS0 register 7.
        xfer("rd_default", 1'b0, 4'h7, 16'h0000, 0, 1'b0, 0, 1'b0, 16'h50A5);

        // Reprogrammed set 1, write to CS1 register 6.
        load_set(1, 1, 3, 1, 2);
        xfer("wr_set1", 1'b1, 4'hE, 16'h1234, 1, 1'b0, 0, 1'b0, 16'hFFFF);

        // IORDY released 10 cycles past T2: 10 stretch cycles plus 2 synchroniser cycles.
        iordy_pad_i = 1'b0;
        fork
            xfer("rd_stretch", 1'b0, 4'h1, 16'h0000, 0, 1'b1, 12, 1'b0, 16'hBEEF);
            begin
                wait_strobe(ok);
                check("stretch_strobe_seen", 32'(ok), 32'd1);
                repeat (tm[0][1] + 10) @(posedge wb_clk_i);
                #1 iordy_pad_i = 1'b1;
            end
        join

        // IORDY stuck low: full timeout, ack and err together.
        iordy_pad_i = 1'b0;
        xfer("rd_timeout", 1'b0, 4'h2, 16'h0000, 1, 1'b1, TOUT, 1'b1, 16'h0F0F);

        // IORDY stuck low but stretching disabled: default timing.
        xfer("rd_noien", 1'b0, 4'h3, 16'h0000, 0, 1'b0, 0, 1'b0, 16'hA55A);
        iordy_pad_i = 1'b1;

        // Load of the in-use set on the request cycle: old values now, all-zero set next time.
        sim_vals[0] = 0; sim_vals[1] = 0; sim_vals[2] = 0; sim_vals[3] = 0;
        sim_ld = 1'b1;
        xfer("wr_sameload", 1'b1, 4'h5, 16'hC3C3, 1, 1'b0, 0, 1'b0, 16'h0000);
        xfer("rd_zero_set", 1'b0, 4'hC, 16'h0000, 1, 1'b0, 0, 1'b0, 16'h7E57);

        // Async reset in mid-strobe: pads inactive at once, no ack, then defaults restored.
        load_set(1, 1, 3, 1, 2);
        @(negedge wb_clk_i);
        req_i = 1'b1; we_i = 1'b1; a_i = 4'h4; d_i = 16'hDEAD; tsel_i = '0; iordy_en_i = 1'b0;
        @(posedge wb_clk_i);
        #1 req_i = 1'b0;
        wait_strobe(ok);
        check("arst_strobe_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge wb_clk_i);
        #2 arst_i = 1'b1;
        #1;
        check("arst_strobes", 32'({diorn_pad_o, diown_pad_o}), 32'd3);
        check("arst_cs", 32'({cs1n_pad_o, cs0n_pad_o}), 32'd3);
        check("arst_bus", 32'({dd_padoe_o, dd_pad_o, da_pad_o}), 32'd0);
        check("arst_busy_ack", 32'({busy_o, ack_o, err_o}), 32'd0);
        @(negedge wb_clk_i);
        arst_i = 1'b0;
        model_reset();
        repeat (2) @(negedge wb_clk_i);
        xfer("rd_after_arst", 1'b0, 4'h7, 16'h0000, 1, 1'b0, 0, 1'b0, 16'h1357);

        // Synchronous reset also restores the timing sets.
        load_set(1, 1, 1, 1, 1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        model_reset();
        check("wbrst_q", 32'(q_o), 32'd0);
        xfer("rd_after_wbrst", 1'b0, 4'h6, 16'h0000, 1, 1'b0, 0, 1'b0, 16'h2468);

        repeat (3) @(negedge wb_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
